// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Byte-serial RAM access that stalls the pipeline until writeback is ready.
module mem_lsu #(
  parameter logic [7:0] OP_LB  = 8'h20,
  parameter logic [7:0] OP_LH  = 8'h21,
  parameter logic [7:0] OP_LW  = 8'h22,
  parameter logic [7:0] OP_LBU = 8'h23,
  parameter logic [7:0] OP_LHU = 8'h24,
  parameter logic [7:0] OP_SB  = 8'h28,
  parameter logic [7:0] OP_SH  = 8'h29,
  parameter logic [7:0] OP_SW  = 8'h2A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] ma_addr_i,
  input  logic        mem_gnt,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_addr,
  output logic        ram_rw,
  output logic [7:0]  ram_dout,
  output logic        mem_req,
  output logic        stallreq_mem,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o
);

  typedef enum logic [1:0] {
    IDLE, RD, WR, DONE
  } state_t;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [3:0][7:0] buf_q;
  logic [3:0][7:0] sdata_q;
  logic [31:0]     base_q;
  logic [7:0]      op_q;
  logic [4:0]      wd_q;
  logic            wreg_q;

  logic            unused_sel;
  assign unused_sel = ^alusel_i;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [2:0] op_size(input logic [7:0] op);
    logic [2:0] n;
    n = 3'd0;
    if (op inside {OP_LB, OP_LBU, OP_SB}) n = 3'd1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) n = 3'd2;
    if (op inside {OP_LW, OP_SW}) n = 3'd4;
    return n;
  endfunction

  logic       mem_op;
  logic [2:0] n_q;
  logic [1:0] cnt_m1;
  logic [31:0] ld_val;

  assign mem_op = is_load(aluop_i) | is_store(aluop_i);
  assign n_q    = op_size(op_q);
  assign cnt_m1 = 2'(cnt_q - 3'd1);

  always_comb begin
    ld_val = buf_q;
    case (op_q)
      OP_LB:   ld_val = {{24{buf_q[0][7]}}, buf_q[0]};
      OP_LBU:  ld_val = {24'h0, buf_q[0]};
      OP_LH:   ld_val = {{16{buf_q[1][7]}}, buf_q[1], buf_q[0]};
      OP_LHU:  ld_val = {16'h0, buf_q[1], buf_q[0]};
      default: ld_val = buf_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      buf_q   <= '0;
      sdata_q <= '0;
      base_q  <= 32'h0;
      op_q    <= 8'h0;
      wd_q    <= 5'h0;
      wreg_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_op && mem_gnt) begin
            base_q  <= ma_addr_i;
            sdata_q <= wdata_i;
            op_q    <= aluop_i;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
            cnt_q   <= 3'd0;
            state_q <= is_load(aluop_i) ? RD : WR;
          end
        end
        RD: begin
          // RAM data trails the address by one cycle
          if (cnt_q != 3'd0) buf_q[cnt_m1] <= ram_din;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == n_q) state_q <= DONE;
        end
        WR: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == n_q - 3'd1) state_q <= DONE;
        end
        DONE: begin
          cnt_q   <= 3'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ram_addr     = 32'h0;
    ram_rw       = 1'b0;
    ram_dout     = 8'h0;
    mem_req      = 1'b0;
    stallreq_mem = 1'b0;
    wd_o         = 5'h0;
    wreg_o       = 1'b0;
    wdata_o      = 32'h0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            mem_req      = 1'b1;
            stallreq_mem = 1'b1;
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        RD: begin
          mem_req      = 1'b1;
          stallreq_mem = 1'b1;
          ram_addr     = base_q + 32'(cnt_q);
        end
        WR: begin
          mem_req      = 1'b1;
          stallreq_mem = 1'b1;
          ram_rw       = 1'b1;
          ram_addr     = base_q + 32'(cnt_q);
          ram_dout     = sdata_q[cnt_q[1:0]];
        end
        DONE: begin
          wd_o = wd_q;
          if (is_load(op_q)) begin
            wreg_o  = wreg_q;
            wdata_o = ld_val;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu.
// Transaction-level model predicts per-cycle outputs; RAM is a byte map.
module tb_mem_lsu;

  localparam logic [7:0] LB  = 8'h20;
  localparam logic [7:0] LH  = 8'h21;
  localparam logic [7:0] LW  = 8'h22;
  localparam logic [7:0] LBU = 8'h23;
  localparam logic [7:0] LHU = 8'h24;
  localparam logic [7:0] SB  = 8'h28;
  localparam logic [7:0] SH  = 8'h29;
  localparam logic [7:0] SW  = 8'h2A;
  localparam logic [7:0] ADD = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] ma_addr_i;
  logic        mem_gnt;
  logic [7:0]  ram_din = 8'h0;
  logic [31:0] ram_addr;
  logic        ram_rw;
  logic [7:0]  ram_dout;
  logic        mem_req;
  logic        stallreq_mem;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .alusel_i(alusel_i),
    .ma_addr_i(ma_addr_i), .mem_gnt(mem_gnt),
    .ram_din(ram_din), .ram_addr(ram_addr),
    .ram_rw(ram_rw), .ram_dout(ram_dout),
    .mem_req(mem_req), .stallreq_mem(stallreq_mem),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [logic [31:0]];
  logic [7:0] mdl [logic [31:0]];

  function automatic logic [7:0] rpeek(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h0;
  endfunction

  function automatic logic [7:0] mpeek(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    mdl[a] = b;
  endtask

  always @(posedge clk) begin
    if (ram_rw) ram[ram_addr] = ram_dout;
    ram_din <= rpeek(ram_addr);
  end

  int pass = 0;
  int total = 0;
  int stall_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_wb = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_rw, e_wreg;
  logic        c_addr, c_dout, c_wb;
  logic [31:0] e_addr, e_dout, e_wdata;
  logic [4:0]  e_wd;

  task automatic set_exp(input logic st, input logic rq, input logic rw,
                         input logic wr, input logic [31:0] a,
                         input logic ca, input logic [31:0] d,
                         input logic cd, input logic [31:0] wdat,
                         input logic cw, input logic [4:0] wd);
    e_stall = st; e_req = rq; e_rw = rw; e_wreg = wr;
    e_addr = a; c_addr = ca; e_dout = d; c_dout = cd;
    e_wdata = wdat; c_wb = cw; e_wd = wd;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallreq_mem", 32'(stallreq_mem), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("ram_rw", 32'(ram_rw), 32'(e_rw));
      chk("wreg_o", 32'(wreg_o), 32'(e_wreg));
      if (c_addr) chk("ram_addr", ram_addr, e_addr);
      if (c_dout) chk("ram_dout", 32'(ram_dout), e_dout);
      if (c_wb) begin
        chk("wdata_o", wdata_o, e_wdata);
        if (e_wreg) chk("wd_o", 32'(wd_o), 32'(e_wd));
      end
      if (stallreq_mem) stall_cnt++;
      if (ram_rw) wr_cnt++;
      if (wreg_o) last_wb = wdata_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pt(input logic [4:0] wd, input logic wr,
                    input logic [31:0] d, input logic [7:0] op);
    wd_i = wd; wreg_i = wr; wdata_i = d; aluop_i = op;
    ma_addr_i = 32'h55; mem_gnt = 1'b1;
    set_exp(0, 0, 0, wr, 0, 1, 0, 1, d, 1, wd);
    chk_en = 1'b1;
    tick();
  endtask

  task automatic mop(input logic [7:0] op, input logic [31:0] addr,
                     input logic [31:0] data, input logic [4:0] wd,
                     input int gdelay, input bit scramble);
    int n;
    bit ld;
    logic [31:0] v;
    n = (op == LB || op == LBU || op == SB) ? 1 :
        (op == LW || op == SW) ? 4 : 2;
    ld = op inside {LB, LH, LW, LBU, LHU};
    v = 32'h0;
    if (ld) begin
      for (int k = 0; k < n; k++)
        v = v | (32'(mpeek(addr + 32'(k))) << (8 * k));
      if ((op == LB || op == LH) && v >= (32'd1 << (8 * n - 1)))
        v = v - (32'd1 << (8 * n));
    end
    wd_i = wd; wreg_i = 1'b1; wdata_i = data; aluop_i = op;
    ma_addr_i = addr; alusel_i = 3'd4; mem_gnt = (gdelay == 0);
    chk_en = 1'b1;
    for (int g = 0; g < gdelay; g++) begin
      set_exp(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      tick();
    end
    mem_gnt = 1'b1;
    set_exp(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    tick();
    mem_gnt = 1'b0;
    if (scramble) begin
      aluop_i = ADD; ma_addr_i = 32'hDEAD0000;
      wdata_i = ~data; wd_i = ~wd;
    end
    if (ld) begin
      for (int k = 0; k <= n; k++) begin
        set_exp(1, 1, 0, 0, addr + 32'(k), k < n, 0, 0, 0, 0, 0);
        tick();
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        set_exp(1, 1, 1, 0, addr + 32'(k), 1,
                32'(data[8*k +: 8]), 1, 0, 0, 0);
        mdl[addr + 32'(k)] = data[8*k +: 8];
        tick();
      end
    end
    set_exp(0, 0, 0, ld, 0, 1, 0, 1, ld ? v : 32'h0, 1, wd);
    tick();
  endtask

  task automatic abort_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int ncyc,
                          input logic rw_exp);
    chk_en = 1'b0;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = data; aluop_i = op;
    ma_addr_i = addr; mem_gnt = 1'b1;
    repeat (1 + ncyc) @(posedge clk);
    #2;
    chk("pre_rst_addr", ram_addr, addr + 32'(ncyc));
    chk("pre_rst_rw", 32'(ram_rw), 32'(rw_exp));
    rst = 1'b0;
    #1;
    chk("rst_rw", 32'(ram_rw), 0);
    chk("rst_stall", 32'(stallreq_mem), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_dout", 32'(ram_dout), 0);
    aluop_i = ADD; wd_i = 5'd9; wdata_i = 32'h55;
    #1;
    chk("rst_wreg", 32'(wreg_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wd", 32'(wd_o), 0);
    mem_gnt = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hFFFFFFFF;
    aluop_i = ADD; alusel_i = 3'd0; ma_addr_i = 32'h0; mem_gnt = 1'b0;
    #3;
    chk("init_wreg", 32'(wreg_o), 0);
    chk("init_wdata", wdata_o, 0);
    chk("init_wd", 32'(wd_o), 0);
    chk("init_stall", 32'(stallreq_mem), 0);
    chk("init_req", 32'(mem_req), 0);
    chk("init_rw", 32'(ram_rw), 0);
    poke(32'h100, 8'h78); poke(32'h101, 8'h56);
    poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    poke(32'h300, 8'h80);
    poke(32'h200, 8'h00); poke(32'h201, 8'h80);
    tick();
    rst = 1'b1;

    pt(5'd5, 1'b1, 32'h1234, ADD);
    pt(5'd6, 1'b0, 32'hA5A5A5A5, 8'h2F);
    pt(5'd31, 1'b1, 32'hDEADBEEF, 8'h25);

    stall_cnt = 0;
    mop(LW, 32'h100, 32'h0, 5'd10, 0, 1'b1);
    chk("lw_stall_cycles", stall_cnt, 6);
    chk("lw_literal", last_wb, 32'h12345678);
    mop(LB, 32'h300, 32'h0, 5'd11, 0, 1'b0);
    chk("lb_literal", last_wb, 32'hFFFFFF80);
    mop(LBU, 32'h300, 32'h0, 5'd11, 0, 1'b0);
    chk("lbu_literal", last_wb, 32'h00000080);
    mop(LH, 32'h200, 32'h0, 5'd12, 0, 1'b1);
    chk("lh_literal", last_wb, 32'hFFFF8000);

    wr_cnt = 0;
    mop(SH, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd12, 0, 1'b1);
    chk("sh_writes", wr_cnt, 2);
    chk("sh_byte_hi", 32'(rpeek(32'hFFFFFFFF)), 32'hDD);
    chk("sh_byte_wrap", 32'(rpeek(32'h0)), 32'hCC);
    mop(LHU, 32'hFFFFFFFF, 32'h0, 5'd14, 0, 1'b0);
    chk("lhu_wrap_literal", last_wb, 32'h0000CCDD);

    stall_cnt = 0;
    wr_cnt = 0;
    mop(SW, 32'h400, 32'hCAFEBABE, 5'd13, 3, 1'b0);
    chk("sw_gnt_stall", stall_cnt, 8);
    chk("sw_writes", wr_cnt, 4);
    mop(LW, 32'h400, 32'h0, 5'd15, 0, 1'b0);
    mop(LH, 32'h401, 32'h0, 5'd16, 0, 1'b0);
    chk("lh_misaligned", last_wb, 32'hFFFFFEBA);
    mop(SB, 32'h402, 32'h00000011, 5'd17, 1, 1'b1);
    mop(LW, 32'h400, 32'h0, 5'd18, 0, 1'b0);
    chk("sb_then_lw", last_wb, 32'hCA11BABE);
    pt(5'd1, 1'b1, 32'h0BADF00D, ADD);

    abort_op(LW, 32'h100, 32'h0, 2, 1'b0);
    pt(5'd5, 1'b1, 32'h1234, ADD);
    abort_op(SW, 32'h800, 32'h01020304, 1, 1'b1);
    pt(5'd2, 1'b1, 32'h00C0FFEE, ADD);
    mop(LW, 32'h100, 32'h0, 5'd20, 0, 1'b0);
    chk("lw_after_rst", last_wb, 32'h12345678);
    chk_en = 1'b0;

    foreach (mdl[a]) chk("ram_vs_model", 32'(rpeek(a)), 32'(mdl[a]));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
